// File: rtl/reg_file.sv
// Architectural register file feeding the ALU: three combinational read ports,
// a main write port plus a link-register write, and an R15 alias that returns PC+8.
module reg_file #(
   parameter int W      = 32,
   parameter int AW     = 4,
   parameter bit BYPASS = 1'b0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] ra1,
   input  logic [AW-1:0] ra2,
   input  logic [AW-1:0] ra3,
   output logic [W-1:0]  rd1,
   output logic [W-1:0]  rd2,
   output logic [W-1:0]  rd3,
   input  logic          we3,
   input  logic [AW-1:0] wa3,
   input  logic [W-1:0]  wd3,
   input  logic          we_lr,
   input  logic [W-1:0]  wd_lr,
   input  logic [W-1:0]  pc_plus8,
   output logic          wr_pc_err
);

   localparam int NSTORE = (2 ** AW) - 1;
   localparam logic [AW-1:0] PC_IDX = '1;
   localparam logic [AW-1:0] LR_IDX = {{(AW-1){1'b1}}, 1'b0};

   typedef logic [W-1:0] word_t;

   word_t regs_q [NSTORE];
   word_t regs_d [NSTORE];
   word_t fwd    [NSTORE];
   logic  wr_pc_err_q;
   logic  wr_pc_err_d;

   logic main_wr;
   logic lr_wr;

   // R15 has no storage, so a main-port write there is dropped and flagged.
   assign main_wr = we3 && (wa3 != PC_IDX);
   assign lr_wr   = we_lr && !(we3 && (wa3 == LR_IDX));

   // NOTE: every always_comb output is given a default first so no path leaves it
   // holding its old value, which would infer a latch.
   always_comb begin
      for (int i = 0; i < NSTORE; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (main_wr) begin
         for (int i = 0; i < NSTORE; i++) begin
            if (wa3 == AW'(i)) regs_d[i] = wd3;
         end
      end
      if (lr_wr) begin
         regs_d[NSTORE-1] = wd_lr;
      end
   end

   assign wr_pc_err_d = we3 && (wa3 == PC_IDX);

   // Forwarded view: committed data this cycle, but never while reset is holding state at 0.
   always_comb begin
      for (int i = 0; i < NSTORE; i++) begin
         fwd[i] = (BYPASS && rst_n) ? regs_d[i] : regs_q[i];
      end
   end

   function automatic word_t read_port(input logic [AW-1:0] addr,
                                       input word_t         pc_val,
                                       input word_t         src [NSTORE]);
      word_t v;
      v = pc_val;
      for (int i = 0; i < NSTORE; i++) begin
         if (addr == AW'(i)) v = src[i];
      end
      return v;
   endfunction

   assign rd1 = read_port(ra1, pc_plus8, fwd);
   assign rd2 = read_port(ra2, pc_plus8, fwd);
   assign rd3 = read_port(ra3, pc_plus8, fwd);

   // NOTE: storage is cleared by reset because architectural state must read 0
   // after reset; state updates use non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NSTORE; i++) begin
            regs_q[i] <= '0;
         end
         wr_pc_err_q <= 1'b0;
      end else begin
         for (int i = 0; i < NSTORE; i++) begin
            regs_q[i] <= regs_d[i];
         end
         wr_pc_err_q <= wr_pc_err_d;
      end
   end

   assign wr_pc_err = wr_pc_err_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: a non-bypass and a bypass instance share stimulus,
// expected values go through a scoreboard queue and are checked by immediate assertions.
module tb_reg_file;

   logic        clk;
   logic        rst_n;
   logic [3:0]  ra1, ra2, ra3, wa3;
   logic        we3, we_lr;
   logic [31:0] wd3, wd_lr, pc_plus8;
   logic [31:0] rd1_nb, rd2_nb, rd3_nb, rd1_by, rd2_by, rd3_by;
   logic        err_nb, err_by;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t        sb [$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] mdl [15];

   reg_file #(.W(32), .AW(4), .BYPASS(1'b0)) u_nb (
      .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .ra3(ra3),
      .rd1(rd1_nb), .rd2(rd2_nb), .rd3(rd3_nb),
      .we3(we3), .wa3(wa3), .wd3(wd3), .we_lr(we_lr), .wd_lr(wd_lr),
      .pc_plus8(pc_plus8), .wr_pc_err(err_nb)
   );

   reg_file #(.W(32), .AW(4), .BYPASS(1'b1)) u_by (
      .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .ra3(ra3),
      .rd1(rd1_by), .rd2(rd2_by), .rd3(rd3_by),
      .we3(we3), .wa3(wa3), .wd3(wd3), .we_lr(we_lr), .wd_lr(wd_lr),
      .pc_plus8(pc_plus8), .wr_pc_err(err_by)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic expect_val(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t e;
      n_checks++;
      if (sb.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty: observed %h required an expected entry", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mdl();
      for (int i = 0; i < 15; i++) mdl[i] = '0;
   endtask

   logic [32:0] alu_sum;
   logic        alu_ovf;

   initial begin
      rst_n = 1'b0;
      we3 = 1'b0; wa3 = '0; wd3 = '0;
      we_lr = 1'b0; wd_lr = '0;
      pc_plus8 = 32'h0000_0108;
      ra1 = 4'd3; ra2 = 4'd15; ra3 = 4'd4;
      clear_mdl();

      // Reset state
      #2;
      expect_val("rst_rd1", 32'h0);        check(rd1_nb);
      expect_val("rst_rd2_pc", 32'h108);   check(rd2_nb);
      expect_val("rst_err", 32'h0);        check({31'h0, err_nb});
      expect_val("rst_rd1_byp", 32'h0);    check(rd1_by);
      #10 rst_n = 1'b1;

      // Write R3, then reset mid-cycle clears it before the next edge
      @(negedge clk);
      we3 = 1'b1; wa3 = 4'd3; wd3 = 32'hDEAD_BEEF;
      tick();
      we3 = 1'b0;
      #1;
      expect_val("r3_written", 32'hDEAD_BEEF); check(rd1_nb);
      #1 rst_n = 1'b0;
      #1;
      expect_val("r3_async_clr", 32'h0);      check(rd1_nb);
      expect_val("r3_async_clr_byp", 32'h0);  check(rd1_by);
      expect_val("err_after_rst", 32'h0);     check({31'h0, err_nb});
      @(negedge clk);
      rst_n = 1'b1;

      // Basic write/read on all three ports
      @(negedge clk);
      we3 = 1'b1; wa3 = 4'd5; wd3 = 32'h1234_5678; ra1 = 4'd5;
      #1;
      expect_val("r5_byp_same_cycle", 32'h1234_5678); check(rd1_by);
      expect_val("r5_nobyp_pre_edge", 32'h0);         check(rd1_nb);
      tick();
      we3 = 1'b0; mdl[5] = 32'h1234_5678;
      ra1 = 4'd5; ra2 = 4'd5; ra3 = 4'd5;
      #1;
      expect_val("r5_rd1", 32'h1234_5678); check(rd1_nb);
      expect_val("r5_rd2", 32'h1234_5678); check(rd2_nb);
      expect_val("r5_rd3", 32'h1234_5678); check(rd3_nb);
      ra3 = 4'd4;
      #1;
      expect_val("r4_zero", 32'h0);        check(rd3_nb);

      // R15 alias and write protection, back-to-back offending writes
      @(negedge clk);
      ra2 = 4'd15;
      #1;
      expect_val("r15_alias", 32'h108);    check(rd2_nb);
      we3 = 1'b1; wa3 = 4'd15; wd3 = 32'hFFFF_FFFF; ra1 = 4'd15;
      #1;
      expect_val("r15_no_bypass", 32'h108); check(rd1_by);
      expect_val("err_pre_edge", 32'h0);    check({31'h0, err_nb});
      tick();
      expect_val("err_pulse", 32'h1);       check({31'h0, err_nb});
      expect_val("err_pulse_byp", 32'h1);   check({31'h0, err_by});
      expect_val("r15_after_wr", 32'h108);  check(rd2_nb);
      tick();
      we3 = 1'b0;
      expect_val("err_held", 32'h1);        check({31'h0, err_nb});
      tick();
      expect_val("err_cleared", 32'h0);     check({31'h0, err_nb});
      pc_plus8 = 32'h0000_0200;
      #1;
      expect_val("r15_follows_pc", 32'h200); check(rd2_nb);
      for (int i = 0; i < 15; i++) begin
         ra1 = 4'(i);
         #1;
         expect_val($sformatf("r%0d_unchanged", i), mdl[i]);
         check(rd1_nb);
      end

      // Dual-write conflict: main port wins on R14
      @(negedge clk);
      we3 = 1'b1; wa3 = 4'd14; wd3 = 32'hAAAA_0000;
      we_lr = 1'b1; wd_lr = 32'h0000_BBBB; ra1 = 4'd14;
      #1;
      expect_val("r14_conflict_byp", 32'hAAAA_0000); check(rd1_by);
      tick();
      we3 = 1'b0; we_lr = 1'b0; mdl[14] = 32'hAAAA_0000;
      #1;
      expect_val("r14_conflict", 32'hAAAA_0000); check(rd1_nb);
      @(negedge clk);
      we3 = 1'b1; wa3 = 4'd2; wd3 = 32'hAAAA_0000;
      we_lr = 1'b1; wd_lr = 32'h0000_BBBB; ra1 = 4'd14; ra2 = 4'd2;
      #1;
      expect_val("r14_lr_byp", 32'h0000_BBBB); check(rd1_by);
      expect_val("r2_main_byp", 32'hAAAA_0000); check(rd2_by);
      tick();
      we3 = 1'b0; we_lr = 1'b0;
      mdl[14] = 32'h0000_BBBB; mdl[2] = 32'hAAAA_0000;
      #1;
      expect_val("r14_lr", 32'h0000_BBBB);  check(rd1_nb);
      expect_val("r2_main", 32'hAAAA_0000); check(rd2_nb);

      // Bypass vs no bypass on R7
      @(negedge clk);
      we3 = 1'b1; wa3 = 4'd7; wd3 = 32'h1;
      tick();
      we3 = 1'b0;
      @(negedge clk);
      we3 = 1'b1; wa3 = 4'd7; wd3 = 32'h2; ra1 = 4'd7;
      #1;
      expect_val("r7_byp_new", 32'h2);   check(rd1_by);
      expect_val("r7_nobyp_old", 32'h1); check(rd1_nb);
      tick();
      we3 = 1'b0; mdl[7] = 32'h2;
      #1;
      expect_val("r7_nobyp_after", 32'h2); check(rd1_nb);

      // Reset across the edge of a pending write loses the write
      @(negedge clk);
      we3 = 1'b1; wa3 = 4'd9; wd3 = 32'hCAFE_F00D;
      #2 rst_n = 1'b0;
      tick();
      we3 = 1'b0; ra1 = 4'd9; ra2 = 4'd2;
      clear_mdl();
      #1;
      expect_val("r9_write_lost", 32'h0); check(rd1_nb);
      expect_val("r2_cleared", 32'h0);    check(rd2_nb);
      @(negedge clk);
      rst_n = 1'b1;

      // ALU hookup: add of R1 and R2 overflows into the sign bit
      @(negedge clk);
      we3 = 1'b1; wa3 = 4'd1; wd3 = 32'h7FFF_FFFF;
      tick();
      @(negedge clk);
      wa3 = 4'd2; wd3 = 32'h0000_0001;
      tick();
      we3 = 1'b0; ra1 = 4'd1; ra2 = 4'd2;
      #1;
      alu_sum = {1'b0, rd1_nb} + {1'b0, rd2_nb};
      alu_ovf = (rd1_nb[31] == rd2_nb[31]) && (alu_sum[31] != rd1_nb[31]);
      expect_val("alu_out", 32'h8000_0000); check(alu_sum[31:0]);
      expect_val("alu_ovf", 32'h1);         check({31'h0, alu_ovf});
      expect_val("alu_n", 32'h1);           check({31'h0, alu_sum[31]});
      expect_val("alu_z", 32'h0);           check({31'h0, (alu_sum[31:0] == 32'h0)});
      expect_val("alu_co", 32'h0);          check({31'h0, alu_sum[32]});

      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $error("FAIL scoreboard_leftover: observed %0d entries required 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: observed no completion required finish before 50000");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file for the single-cycle CPU datapath, sitting directly upstream of the ALU. It supplies the ALU operand buses A and B and a third read value for store data. It holds R0–R14 as flops and returns an externally supplied PC+8 value for R15. Writes are taken on the clock edge from the writeback path, with an independent link-register write for branch-with-link.

## Interface
- W, 32, data width; must match ALU W
- AW, 4, address width; 2**AW registers, top index is the PC alias
- BYPASS, 0, 1 = same-cycle write-to-read forwarding on all read ports
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- ra1  input  AW  read address, port 1 (ALU operand A)
- ra2  input  AW  read address, port 2 (ALU operand B)
- ra3  input  AW  read address, port 3 (store data)
- rd1, rd2, rd3  output  W each  read data, ports 1–3
- we3  input  1  write enable, main write port
- wa3  input  AW  write address, main port
- wd3  input  W  write data, main port
- we_lr  input  1  link write enable; target is register 2**AW-2 (R14)
- wd_lr  input  W  link write data
- pc_plus8  input  W  value returned for reads of index 2**AW-1 (R15)
- wr_pc_err  output  1  registered; pulses when a write to R15 is attempted

## Operation
- Storage: registers 0 … 2**AW-2 (R0–R14 for AW=4) as W-bit flops. Index 2**AW-1 has no storage.
- Reads are combinational.
  - rdN = pc_plus8 when raN = 2**AW-1.
  - Otherwise rdN = the stored value.
- BYPASS=1: if a write to raN is being committed this cycle, rdN = the data being written (after write-priority resolution). R15 reads are never bypassed.
- BYPASS=0: reads always return pre-edge stored values.
- Write port priority on the rising clk edge:
  - we3=1 and wa3 ≠ R15: reg[wa3] <= wd3.
  - we_lr=1: R14 <= wd_lr, unless we3=1 and wa3=R14 in the same cycle. In that case the main port wins and wd_lr is dropped.
  - we3=1 and wa3 = R15: no storage update. wr_pc_err is 1 for the next cycle. The PC is owned by the fetch stage.
- Both write ports active to different registers in one cycle: both commit.
- Write-only behaviour, no read-modify. The full W bits are always written; there are no byte enables.

## Timing
- Reset (rst_n low, asynchronous): all stored registers clear to 0 immediately and wr_pc_err clears to 0.
  - rdN follows the cleared values combinationally; R15 reads still return pc_plus8.
- Deassertion: the first write can commit at the first rising clk edge with rst_n high.
- If reset asserts in the same cycle as a pending write, the write is lost and the register reads 0.
- Write latency: 1 edge. The value is visible on reads in the cycle after the edge, or in the same cycle when BYPASS=1.
- Read latency: 0 cycles, purely combinational from raN, stored values and pc_plus8.
- wr_pc_err: 1-cycle pulse per offending write. Back-to-back offending writes hold it high.
- There is no stall or handshake. Every enabled write commits unconditionally at the edge.

## Test plan
- Reset clear:
  - Write 0xDEADBEEF to R3, then assert rst_n=0 mid-cycle → rd1 (ra1=3) reads 0x00000000 before the next edge.
  - wr_pc_err = 0.
- Basic write/read:
  - we3=1, wa3=5, wd3=0x12345678 → after the edge, rd1/rd2/rd3 with address 5 all read 0x12345678.
  - R4 still reads 0.
- R15 alias and protection:
  - pc_plus8=0x00000108, ra2=15 → rd2=0x00000108.
  - we3=1, wa3=15, wd3=0xFFFFFFFF → the next cycle has wr_pc_err=1 and rd2 still reads pc_plus8.
  - Registers R0–R14 are unchanged.
- Dual-write conflict:
  - we3=1, wa3=14, wd3=0xAAAA0000 with we_lr=1, wd_lr=0x0000BBBB → R14 = 0xAAAA0000.
  - Repeat with wa3=2 → R2 = 0xAAAA0000 and R14 = 0x0000BBBB.
- Bypass:
  - BYPASS=1, R7 holds 0x1, we3=1, wa3=7, wd3=0x2, ra1=7 → rd1 = 0x2 in the same cycle.
  - BYPASS=0 → rd1 = 0x1 until the edge, then 0x2.
- ALU hookup:
  - R1=0x7FFFFFFF, R2=0x00000001, rd1/rd2 to ALU A/B with cntl=00 → ALU out = 0x80000000, OVF=1, N=1, Z=0, CO=0.
